// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART/ALU frame path: opcode values, FSM encodings
// and the opcode legality check used by the sequencer, the ALU and the benches.
package alu_uart_pkg;

   localparam int NB_BYTE_DEF = 8;
   localparam int SIZEOP_DEF  = 6;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_SRA = 6'b000011;

   typedef enum logic [2:0] {
      ST_RX_A,
      ST_RX_B,
      ST_RX_OP,
      ST_EXEC,
      ST_TX
   } frame_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_LOAD,
      TX_WAIT
   } tx_state_t;

   function automatic logic op_is_legal(input logic [31:0] op);
      case (op)
         32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR),
         32'(OP_XOR), 32'(OP_NOR), 32'(OP_SRL), 32'(OP_SRA): op_is_legal = 1'b1;
         default:                                            op_is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_uart_sequencer_result_serializer.sv
// Captures the ALU result on load and streams it LSB byte first: one-cycle start
// pulse per byte, next byte only after i_tx_done; o_busy spans load to last done.
module result_serializer
   import alu_uart_pkg::*;
#(
   parameter int NB_BYTE    = NB_BYTE_DEF,
   parameter int N_BYTES_OP = 1
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_load,
   input  logic [NB_BYTE*N_BYTES_OP-1:0] i_result,
   input  logic                          i_tx_done,
   output logic                          o_tx_start,
   output logic [NB_BYTE-1:0]            o_tx_data,
   output logic                          o_busy,
   output logic                          o_done
);

   localparam int DATA_WIDTH = NB_BYTE * N_BYTES_OP;
   localparam int IDXW       = $clog2(N_BYTES_OP + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_BYTES_OP - 1);

   tx_state_t             st_q, st_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic [IDXW-1:0]       idx_q, idx_d;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         st_q  <= TX_IDLE;
         res_q <= '0;
         idx_q <= '0;
      end else begin
         st_q  <= st_d;
         res_q <= res_d;
         idx_q <= idx_d;
      end
   end

   always_comb begin
      st_d       = st_q;
      res_d      = res_q;
      idx_d      = idx_q;
      o_tx_start = 1'b0;
      o_done     = 1'b0;
      case (st_q)
         TX_IDLE: begin
            if (i_load) begin
               res_d = i_result;
               idx_d = '0;
               st_d  = TX_LOAD;
            end
         end
         TX_LOAD: begin
            o_tx_start = 1'b1;
            st_d       = TX_WAIT;
         end
         TX_WAIT: begin
            // tx_done seen in any other state is stray and ignored
            if (i_tx_done) begin
               if (idx_q == LAST_IDX) begin
                  o_done = 1'b1;
                  idx_d  = '0;
                  st_d   = TX_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  st_d  = TX_LOAD;
               end
            end
         end
         default: st_d = TX_IDLE;
      endcase
   end

   assign o_tx_data = res_q[NB_BYTE*int'(idx_q) +: NB_BYTE];
   assign o_busy    = i_load || (st_q != TX_IDLE);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Builds A/B/opcode frames from UART RX bytes, runs the ALU and returns the result
// over TX; result is captured 1 clock after the opcode byte, RX bytes while busy are dropped.
module alu_uart_sequencer
   import alu_uart_pkg::*;
#(
   parameter int NB_BYTE        = NB_BYTE_DEF,
   parameter int N_BYTES_OP     = 1,
   parameter int SIZEOP         = SIZEOP_DEF,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_rx_done,
   input  logic [NB_BYTE-1:0]            i_rx_data,
   output logic [NB_BYTE*N_BYTES_OP-1:0] o_alu_a,
   output logic [NB_BYTE*N_BYTES_OP-1:0] o_alu_b,
   output logic [SIZEOP-1:0]             o_alu_op,
   input  logic [NB_BYTE*N_BYTES_OP-1:0] i_alu_result,
   output logic                          o_tx_start,
   output logic [NB_BYTE-1:0]            o_tx_data,
   input  logic                          i_tx_done,
   output logic                          o_busy,
   output logic                          o_frame_error,
   output logic                          o_overrun
);

   localparam int DATA_WIDTH = NB_BYTE * N_BYTES_OP;
   localparam int IDXW       = $clog2(N_BYTES_OP + 1);
   localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_BYTES_OP - 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   frame_state_t          state_q, state_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [SIZEOP-1:0]     op_q, op_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic                  ser_done;
   logic                  op_legal;
   logic                  tmo_run;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_RX_A;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         tmo_q       <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         tmo_q       <= tmo_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      tmo_d       = tmo_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      op_legal = ((i_rx_data >> SIZEOP) == '0) && op_is_legal(32'(i_rx_data[SIZEOP-1:0]));
      tmo_run  = (state_q == ST_RX_A && idx_q != '0) || state_q == ST_RX_B || state_q == ST_RX_OP;

      if (i_rx_done)    tmo_d = '0;
      else if (tmo_run) tmo_d = tmo_q + 1'b1;

      case (state_q)
         ST_RX_A: begin
            if (i_rx_done) begin
               a_d[NB_BYTE*int'(idx_q) +: NB_BYTE] = i_rx_data;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_RX_B;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_RX_B: begin
            if (i_rx_done) begin
               b_d[NB_BYTE*int'(idx_q) +: NB_BYTE] = i_rx_data;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_RX_OP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_RX_OP: begin
            if (i_rx_done) begin
               if (op_legal) begin
                  op_d    = i_rx_data[SIZEOP-1:0];
                  state_d = ST_EXEC;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_RX_A;
               end
            end
         end
         ST_EXEC: state_d = ST_TX;
         ST_TX:   if (ser_done) state_d = ST_RX_A;
         default: state_d = ST_RX_A;
      endcase

      if (i_rx_done && (state_q == ST_EXEC || state_q == ST_TX)) overrun_d = 1'b1;

      // a byte landing in the expiry cycle keeps the frame alive
      if (!i_rx_done && tmo_run && tmo_q == TMO_LAST) begin
         frame_err_d = 1'b1;
         state_d     = ST_RX_A;
         idx_d       = '0;
         tmo_d       = '0;
      end
   end

   result_serializer #(
      .NB_BYTE    (NB_BYTE),
      .N_BYTES_OP (N_BYTES_OP)
   ) u_serializer (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (state_q == ST_EXEC),
      .i_result   (i_alu_result),
      .i_tx_done  (i_tx_done),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data),
      .o_busy     (o_busy),
      .o_done     (ser_done)
   );

   assign o_alu_a       = a_q;
   assign o_alu_b       = b_q;
   assign o_alu_op      = op_q;
   assign o_frame_error = frame_err_q;
   assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench: an 8-bit and a 16-bit sequencer share clock/reset; a TX responder
// pops expected bytes from per-instance scoreboards on every o_tx_start.
`timescale 1ns/1ps
module tb_alu_uart_sequencer;
   import alu_uart_pkg::*;

   localparam int T   = 20;
   localparam int GAP = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       rx_done1 = 1'b0, tx_done1 = 1'b0;
   logic [7:0] rx_data1 = '0;
   logic [7:0] a1, b1, res1, tx_data1;
   logic [5:0] op1;
   logic       tx_start1, busy1, fe1, ov1;

   logic        rx_done2 = 1'b0, tx_done2 = 1'b0;
   logic [7:0]  rx_data2 = '0;
   logic [15:0] a2, b2, res2;
   logic [7:0]  tx_data2;
   logic [5:0]  op2;
   logic        tx_start2, busy2, fe2, ov2;

   int checks = 0, failures = 0;
   int starts1 = 0, starts2 = 0;
   int fe_cnt1 = 0, ov_cnt1 = 0, fe_cnt2 = 0, ov_cnt2 = 0;
   bit hold1 = 1'b0;
   logic [7:0] exp_q1[$];
   logic [7:0] exp_q2[$];

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [5:0] op, input int w);
      logic signed [15:0] sa;
      sa = (w == 8) ? {{8{a[7]}}, a[7:0]} : a;
      case (op)
         OP_ADD:  alu_model = a + b;
         OP_SUB:  alu_model = a - b;
         OP_AND:  alu_model = a & b;
         OP_OR:   alu_model = a | b;
         OP_XOR:  alu_model = a ^ b;
         OP_NOR:  alu_model = ~(a | b);
         OP_SRL:  alu_model = a >> b;
         OP_SRA:  alu_model = sa >>> b;
         default: alu_model = '0;
      endcase
   endfunction

   always_comb res1 = 8'(alu_model({8'h00, a1}, {8'h00, b1}, op1, 8));
   always_comb res2 = alu_model(a2, b2, op2, 16);

   alu_uart_sequencer #(.NB_BYTE(8), .N_BYTES_OP(1), .SIZEOP(6), .TIMEOUT_CYCLES(T)) u_dut1 (
      .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done1), .i_rx_data(rx_data1),
      .o_alu_a(a1), .o_alu_b(b1), .o_alu_op(op1), .i_alu_result(res1),
      .o_tx_start(tx_start1), .o_tx_data(tx_data1), .i_tx_done(tx_done1),
      .o_busy(busy1), .o_frame_error(fe1), .o_overrun(ov1));

   alu_uart_sequencer #(.NB_BYTE(8), .N_BYTES_OP(2), .SIZEOP(6), .TIMEOUT_CYCLES(T)) u_dut2 (
      .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done2), .i_rx_data(rx_data2),
      .o_alu_a(a2), .o_alu_b(b2), .o_alu_op(op2), .i_alu_result(res2),
      .o_tx_start(tx_start2), .o_tx_data(tx_data2), .i_tx_done(tx_done2),
      .o_busy(busy2), .o_frame_error(fe2), .o_overrun(ov2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // TX responder, instance 1
   int wait1 = -1;
   logic [7:0] cur1 = '0;
   always @(negedge clk) begin
      tx_done1 = 1'b0;
      if (rst) begin
         wait1 = -1;
      end else if (tx_start1) begin
         starts1++;
         check("tx1_pending", 32'(exp_q1.size() != 0), 32'd1);
         if (exp_q1.size() != 0) begin
            cur1 = exp_q1.pop_front();
            check("tx1_byte", 32'(tx_data1), 32'(cur1));
         end
         wait1 = GAP;
      end else if (wait1 > 0) begin
         wait1--;
      end else if (wait1 == 0 && !hold1) begin
         check("tx1_byte_stable", 32'(tx_data1), 32'(cur1));
         tx_done1 = 1'b1;
         wait1    = -1;
      end
   end

   // TX responder, instance 2
   int wait2 = -1;
   logic [7:0] cur2 = '0;
   always @(negedge clk) begin
      tx_done2 = 1'b0;
      if (rst) begin
         wait2 = -1;
      end else if (tx_start2) begin
         starts2++;
         check("tx2_pending", 32'(exp_q2.size() != 0), 32'd1);
         if (exp_q2.size() != 0) begin
            cur2 = exp_q2.pop_front();
            check("tx2_byte", 32'(tx_data2), 32'(cur2));
         end
         wait2 = GAP;
      end else if (wait2 > 0) begin
         wait2--;
      end else if (wait2 == 0) begin
         check("tx2_byte_stable", 32'(tx_data2), 32'(cur2));
         tx_done2 = 1'b1;
         wait2    = -1;
      end
   end

   always @(negedge clk) begin
      if (fe1) fe_cnt1++;
      if (ov1) ov_cnt1++;
      if (fe2) fe_cnt2++;
      if (ov2) ov_cnt2++;
   end

   task automatic send(input int sel, input logic [7:0] d);
      @(negedge clk);
      if (sel == 1) begin rx_data1 = d; rx_done1 = 1'b1; end
      else          begin rx_data2 = d; rx_done2 = 1'b1; end
      @(negedge clk);
      rx_done1 = 1'b0;
      rx_done2 = 1'b0;
   endtask

   task automatic wait_idle(input int sel, input string tag);
      int n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (((sel == 1) ? busy1 : busy2) && n < 300);
      check(tag, 32'((sel == 1) ? busy1 : busy2), 32'd0);
   endtask

   initial begin
      int s0, f0, o0, cnt;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_a1", 32'(a1), 32'h0);
      check("rst_b1", 32'(b1), 32'h0);
      check("rst_op1", 32'(op1), 32'h0);
      check("rst_tx_start1", 32'(tx_start1), 32'h0);
      check("rst_tx_data1", 32'(tx_data1), 32'h0);
      check("rst_busy1", 32'(busy1), 32'h0);
      check("rst_fe1", 32'(fe1), 32'h0);
      check("rst_ov1", 32'(ov1), 32'h0);
      check("rst_a2", 32'(a2), 32'h0);
      check("rst_busy2", 32'(busy2), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // 8-bit ADD 5+3
      s0 = starts1;
      exp_q1.push_back(8'h08);
      send(1, 8'h05); send(1, 8'h03); send(1, 8'h20);
      #1;
      check("add_op", 32'(op1), 32'(OP_ADD));
      check("add_a", 32'(a1), 32'h05);
      check("add_b", 32'(b1), 32'h03);
      check("add_busy_exec", 32'(busy1), 32'h1);
      wait_idle(1, "add_idle");
      check("add_starts", 32'(starts1 - s0), 32'd1);

      // 16-bit SUB 0x1234-0x0101, little-endian
      s0 = starts2;
      exp_q2.push_back(8'h33);
      exp_q2.push_back(8'h11);
      send(2, 8'h34); send(2, 8'h12); send(2, 8'h01); send(2, 8'h01); send(2, 8'h22);
      #1;
      check("sub16_a", 32'(a2), 32'h1234);
      check("sub16_b", 32'(b2), 32'h0101);
      check("sub16_op", 32'(op2), 32'(OP_SUB));
      wait_idle(2, "sub16_idle");
      check("sub16_starts", 32'(starts2 - s0), 32'd2);

      // illegal opcodes: unlisted value, then a listed value with a stray high bit
      s0 = starts1; f0 = fe_cnt1;
      send(1, 8'h10); send(1, 8'h20); send(1, 8'h3F);
      @(negedge clk); #1;
      check("illegal_fe", 32'(fe_cnt1 - f0), 32'd1);
      check("illegal_op_held", 32'(op1), 32'(OP_ADD));
      check("illegal_busy", 32'(busy1), 32'h0);
      send(1, 8'h01); send(1, 8'h01); send(1, 8'h60);
      @(negedge clk); #1;
      check("highbit_fe", 32'(fe_cnt1 - f0), 32'd2);
      check("illegal_no_tx", 32'(starts1 - s0), 32'd0);
      exp_q1.push_back(8'hFC);
      send(1, 8'hF0); send(1, 8'h02); send(1, 8'h03);
      wait_idle(1, "sra_idle");
      check("sra_starts", 32'(starts1 - s0), 32'd1);
      check("sra_fe_quiet", 32'(fe_cnt1 - f0), 32'd2);

      // inter-byte timeout
      f0 = fe_cnt1;
      send(1, 8'h05);
      cnt = 1;
      do begin
         @(negedge clk); #1;
         cnt++;
      end while (!fe1 && cnt < 100);
      check("timeout_latency", 32'(cnt), 32'(T + 1));
      @(negedge clk); #1;
      check("timeout_pulse", 32'(fe_cnt1 - f0), 32'd1);

      // byte in the expiry cycle is accepted
      s0 = starts1; f0 = fe_cnt1;
      send(1, 8'h07);
      repeat (T - 2) @(negedge clk);
      send(1, 8'h02);
      exp_q1.push_back(8'h05);
      send(1, 8'h22);
      wait_idle(1, "expiry_idle");
      check("expiry_no_fe", 32'(fe_cnt1 - f0), 32'd0);
      check("expiry_starts", 32'(starts1 - s0), 32'd1);

      // RX byte during TX_WAIT
      s0 = starts1; o0 = ov_cnt1;
      exp_q1.push_back(8'h06);
      send(1, 8'h0C); send(1, 8'h0A); send(1, 8'h26);
      @(negedge clk);
      send(1, 8'hAA);
      #1;
      check("overrun_pulse", 32'(ov_cnt1 - o0), 32'd1);
      wait_idle(1, "overrun_idle");
      check("overrun_starts", 32'(starts1 - s0), 32'd1);
      exp_q1.push_back(8'h03);
      send(1, 8'h0F); send(1, 8'h33); send(1, 8'h24);
      #1;
      check("post_ov_a", 32'(a1), 32'h0F);
      check("post_ov_b", 32'(b1), 32'h33);
      wait_idle(1, "post_ov_idle");

      // reset while waiting for tx_done
      hold1 = 1'b1;
      exp_q1.push_back(8'h08);
      send(1, 8'h05); send(1, 8'h03); send(1, 8'h20);
      repeat (2) @(negedge clk);
      check("pre_rst_busy", 32'(busy1), 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_a", 32'(a1), 32'h0);
      check("mid_rst_b", 32'(b1), 32'h0);
      check("mid_rst_op", 32'(op1), 32'h0);
      check("mid_rst_tx_data", 32'(tx_data1), 32'h0);
      check("mid_rst_tx_start", 32'(tx_start1), 32'h0);
      check("mid_rst_busy", 32'(busy1), 32'h0);
      check("mid_rst_fe_ov", 32'({fe1, ov1}), 32'h0);
      s0 = starts1;
      @(negedge clk);
      rst   = 1'b0;
      hold1 = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      check("post_rst_no_start", 32'(starts1 - s0), 32'd0);
      exp_q1.push_back(8'h05);
      send(1, 8'h09); send(1, 8'h04); send(1, 8'h22);
      wait_idle(1, "fresh_idle");
      check("fresh_starts", 32'(starts1 - s0), 32'd1);

      check("q1_drained", 32'(exp_q1.size()), 32'd0);
      check("q2_drained", 32'(exp_q2.size()), 32'd0);
      check("dut2_quiet", 32'(fe_cnt2 + ov_cnt2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
